// File: rtl/sequential_divider.sv
// ---------------------------------------------------------------------------
// sequential_divider
//   Unsigned restoring divider producing one quotient bit per clock. It shares
//   the Start/Ready handshake and the A/Q/B/P register datapath of the
//   shift-add sequential multiplier.
//
// Ports
//   clock        system clock, all state changes on its rising edge
//   reset        synchronous active-high reset
//   Start        operation request, sampled only while Ready=1
//   Dividend     unsigned numerator, sampled with Start
//   Divisor      unsigned denominator, sampled with Start
//   Quotient     registered quotient (all ones on divide-by-zero)
//   Remainder    registered remainder (Dividend on divide-by-zero)
//   Ready        1 = idle, results valid, new Start accepted
//   Div_by_zero  1 = last accepted operation had Divisor=0
// ---------------------------------------------------------------------------
module sequential_divider #(
    parameter int dp_width = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                Start,
    input  logic [dp_width-1:0] Dividend,
    input  logic [dp_width-1:0] Divisor,
    output logic [dp_width-1:0] Quotient,
    output logic [dp_width-1:0] Remainder,
    output logic                Ready,
    output logic                Div_by_zero
);

    localparam int PW = $clog2(dp_width + 1);
    localparam logic [PW-1:0] P_INIT = PW'(dp_width);
    localparam logic [PW-1:0] P_ONE  = PW'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ITER = 1'b1
    } state_t;

    state_t state_r;
    state_t state_next_s;

    // Datapath registers keep their historical names so they can be probed.
    logic [dp_width:0]   A;   // partial remainder
    logic [dp_width-1:0] Q;   // dividend in, quotient out
    logic [dp_width-1:0] B;   // divisor
    logic [PW-1:0]       P;   // remaining iterations

    logic [dp_width-1:0] quotient_r;
    logic [dp_width-1:0] remainder_r;
    logic                ready_r;
    logic                dbz_r;

    logic                divisor_zero_s;
    logic                load_s;
    logic                zero_load_s;
    logic                iter_s;
    logic                last_s;

    logic [dp_width+1:0] trial_s;
    logic [dp_width:0]   a_next_s;
    logic [dp_width-1:0] q_next_s;

    assign divisor_zero_s = (Divisor == {dp_width{1'b0}});

    // One restoring step: shift {A,Q} left, trial-subtract B, keep or restore.
    // A never exceeds B-1, so {A, Q[msb]} is the shifted partial remainder and
    // the extra top bit of trial_s acts as the borrow/sign bit.
    always_comb begin
        trial_s  = {A, Q[dp_width-1]} - {2'b00, B};
        a_next_s = {A[dp_width-1:0], Q[dp_width-1]};
        q_next_s = {Q[dp_width-2:0], 1'b0};
        if (trial_s[dp_width+1] == 1'b0) begin
            a_next_s = trial_s[dp_width:0];
            q_next_s = {Q[dp_width-2:0], 1'b1};
        end else begin
            a_next_s = {A[dp_width-1:0], Q[dp_width-1]};
            q_next_s = {Q[dp_width-2:0], 1'b0};
        end
    end

    // FSM state register; Ready is registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_IDLE;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == S_IDLE);
        end
    end

    // FSM next-state logic; a zero divisor is answered without iterating.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (Start && !divisor_zero_s) begin
                    state_next_s = S_ITER;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ITER: begin
                if (P == P_ONE) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_ITER;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // FSM output decode: datapath control strobes.
    always_comb begin
        load_s      = 1'b0;
        zero_load_s = 1'b0;
        iter_s      = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                load_s      = Start && !divisor_zero_s;
                zero_load_s = Start && divisor_zero_s;
            end
            S_ITER: begin
                iter_s = 1'b1;
                last_s = (P == P_ONE);
            end
            default: begin
                load_s      = 1'b0;
                zero_load_s = 1'b0;
            end
        endcase
    end

    // Datapath and result registers; results move only on load or final step.
    always_ff @(posedge clock) begin
        if (reset) begin
            A           <= {(dp_width+1){1'b0}};
            Q           <= {dp_width{1'b0}};
            B           <= {dp_width{1'b0}};
            P           <= {PW{1'b0}};
            quotient_r  <= {dp_width{1'b0}};
            remainder_r <= {dp_width{1'b0}};
            dbz_r       <= 1'b0;
        end else if (load_s) begin
            A     <= {(dp_width+1){1'b0}};
            Q     <= Dividend;
            B     <= Divisor;
            P     <= P_INIT;
            dbz_r <= 1'b0;
        end else if (zero_load_s) begin
            quotient_r  <= {dp_width{1'b1}};
            remainder_r <= Dividend;
            dbz_r       <= 1'b1;
        end else if (iter_s) begin
            A <= a_next_s;
            Q <= q_next_s;
            P <= P - P_ONE;
            if (last_s) begin
                quotient_r  <= q_next_s;
                remainder_r <= a_next_s[dp_width-1:0];
            end
        end
    end

    assign Quotient    = quotient_r;
    assign Remainder   = remainder_r;
    assign Ready       = ready_r;
    assign Div_by_zero = dbz_r;

endmodule

// File: tb/tb_sequential_divider.sv
// ---------------------------------------------------------------------------
// tb_sequential_divider
//   Directed stimulus with a scoreboard: the driver queues the expected result
//   of every request it expects to be accepted; a monitor on the falling edge
//   tracks the Start/Ready handshake and compares when a result is presented.
// ---------------------------------------------------------------------------
module tb_sequential_divider;

    localparam int W = 5;

    logic         clock;
    logic         reset;
    logic         Start;
    logic [W-1:0] Dividend;
    logic [W-1:0] Divisor;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         Ready;
    logic         Div_by_zero;

    sequential_divider #(.dp_width(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .Start       (Start),
        .Dividend    (Dividend),
        .Divisor     (Divisor),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .Ready       (Ready),
        .Div_by_zero (Div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int q;
        int r;
        int dz;
        int busy;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int q, input int r, input int dz, input int busy);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz; e.busy = busy;
        sb.push_back(e);
    endtask

    // Monitor: counts busy cycles of each accepted request, compares on completion.
    initial begin : monitor
        bit   in_flight = 1'b0;
        int   busy_cnt  = 0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (in_flight && Ready) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient",    int'(Quotient),    e.q);
                    chk("remainder",   int'(Remainder),   e.r);
                    chk("div_by_zero", int'(Div_by_zero), e.dz);
                    chk("busy_cycles", busy_cnt,          e.busy);
                end
                in_flight = 1'b0;
            end else if (in_flight) begin
                busy_cnt++;
                if (busy_cnt > 40) begin
                    chk("busy_timeout", busy_cnt, W);
                    in_flight = 1'b0;
                    if (sb.size() > 0) void'(sb.pop_front());
                end
            end
            if (reset) begin
                if (in_flight && sb.size() > 0) void'(sb.pop_front());
                in_flight = 1'b0;
            end else if (Ready && Start) begin
                in_flight = 1'b1;
                busy_cnt  = 0;
            end
        end
    end

    // Wait (bounded) until Ready is high, sampling just after rising edges.
    task automatic wait_idle();
        int n = 0;
        while (!Ready && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        if (!Ready) chk("ready_timeout", 0, 1);
    endtask

    // One request with hand-supplied expectation; called at posedge+1 with Ready=1.
    task automatic do_op(input int a, input int b, input int q, input int r);
        Start    = 1'b1;
        Dividend = W'(a);
        Divisor  = W'(b);
        if (b == 0) push_exp(q, r, 1, 0);
        else        push_exp(q, r, 0, W);
        @(posedge clock); #1;
        Start = 1'b0;
        wait_idle();
    endtask

    // Directed stimulus sequence.
    initial begin : driver
        reset    = 1'b1;
        Start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready",     int'(Ready),       1);
        chk("rst_quotient",  int'(Quotient),    0);
        chk("rst_remainder", int'(Remainder),   0);
        chk("rst_dbz",       int'(Div_by_zero), 0);
        chk("rst_A",         int'(dut.A),       0);
        chk("rst_P",         int'(dut.P),       0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Basic and boundary operands.
        do_op(23, 5, 4, 3);
        do_op(31, 1, 31, 0);
        do_op(31, 31, 1, 0);
        do_op(7, 9, 0, 7);
        do_op(0, 3, 0, 0);

        // Divide by zero, then a normal operation clears the flag.
        do_op(19, 0, 31, 19);
        do_op(23, 5, 4, 3);

        // A second Start two cycles into an operation is ignored.
        Start = 1'b1; Dividend = 5'd23; Divisor = 5'd5;
        push_exp(4, 3, 0, W);
        @(posedge clock); #1;
        Start = 1'b0;
        @(posedge clock); #1;
        Start = 1'b1; Dividend = 5'd30; Divisor = 5'd7;
        @(posedge clock); #1;
        Start = 1'b0; Dividend = 5'd0; Divisor = 5'd0;
        wait_idle();
        @(posedge clock); #1;

        // Reset on the third cycle of an operation.
        Start = 1'b1; Dividend = 5'd23; Divisor = 5'd5;
        push_exp(4, 3, 0, W);
        @(posedge clock); #1;
        Start = 1'b0;
        @(posedge clock); #1;
        chk("midop_busy", int'(Ready), 0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("abort_ready",     int'(Ready),     1);
        chk("abort_quotient",  int'(Quotient),  0);
        chk("abort_remainder", int'(Remainder), 0);
        chk("abort_P",         int'(dut.P),     0);
        do_op(27, 4, 6, 3);

        // Start held high: three back-to-back operations.
        Start = 1'b1; Dividend = 5'd20; Divisor = 5'd6;
        for (int i = 0; i < 3; i++) push_exp(3, 2, 0, W);
        repeat (13) @(posedge clock);
        #1;
        Start = 1'b0;
        wait_idle();

        // Every dividend against every nonzero divisor.
        for (int a = 0; a < 32; a++) begin
            for (int b = 1; b < 32; b++) begin
                do_op(a, b, a / b, a % b);
            end
        end

        repeat (3) @(posedge clock);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sequential_divider.md
Name: sequential_divider

Overview:
- Unsigned sequential restoring divider, one quotient bit per clock. It is the inverse companion to the team's shift-add sequential multiplier.
- Uses the same Start/Ready handshake and the same register-level datapath style (A, Q, B, P registers).
- Takes a dp_width-bit Dividend and Divisor and produces a dp_width-bit Quotient and Remainder.
- Flags divide-by-zero.

Parameters:
- dp_width, 5, operand/result width in bits (legal range 2..16).

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
- Start  input  1  request; sampled only while Ready=1.
- Dividend  input  dp_width  unsigned numerator; sampled with Start.
- Divisor  input  dp_width  unsigned denominator; sampled with Start.
- Quotient  output  dp_width  registered quotient.
- Remainder  output  dp_width  registered remainder.
- Ready  output  1  1 = idle, results valid, new Start accepted.
- Div_by_zero  output  1  1 = last accepted operation had Divisor=0.

Behaviour:
- One clock domain. Reset is synchronous and active-high; the clock port is named clock and the reset port is named reset.
- Reset (any state, including mid-operation):
  - state=S_IDLE; Ready=1; Quotient=0; Remainder=0; Div_by_zero=0; A=0; Q=0; B=0; P=0.
  - Reset has priority over Start.
- Internal registers (named for bench probing):
  - A: dp_width+1 bits, partial remainder.
  - Q: dp_width bits, dividend/quotient shift register.
  - B: dp_width bits, divisor.
  - P: iteration counter, $clog2(dp_width+1) bits.
- S_IDLE: Ready=1.
  - Start=1 and Divisor!=0, at the edge:
    - A<=0; Q<=Dividend; B<=Divisor; P<=dp_width.
    - Div_by_zero<=0; state<=S_ITER.
  - Start=1 and Divisor==0, at the edge:
    - No iteration; state stays S_IDLE; Ready stays 1.
    - Quotient<=all ones; Remainder<=Dividend; Div_by_zero<=1.
  - Start=0: hold all outputs.
- S_ITER: Ready=0. Each edge:
  - Form {A',Q'} = {A,Q} shifted left by 1.
  - Compute T = A' - {1'b0,B}, at dp_width+2 bits.
  - If T is non-negative (MSB=0): A<=T[dp_width:0] and Q<=Q' with Q[0]=1.
  - Otherwise: A<=A' and Q<=Q' with Q[0]=0.
  - P<=P-1.
  - On the edge where P is 1 before decrement:
    - Apply the iteration above.
    - Quotient<=final Q value; Remainder<=final A[dp_width-1:0].
    - state<=S_IDLE.
- Latency:
  - Start accepted at edge k → Ready low after edge k.
  - Ready high again after edge k+dp_width.
  - Results valid in the same cycle Ready returns high.
  - Busy for exactly dp_width cycles.
- Start while Ready=0 is ignored; operands changing mid-operation have no effect.
- Start held high continuously is re-accepted in the first S_IDLE cycle, giving back-to-back operations with one idle cycle between them.
- Quotient, Remainder and Div_by_zero hold their values until the next accepted Start or reset. They do not change during S_ITER.
- Invariant for Divisor!=0: Dividend = Quotient*Divisor + Remainder, with Remainder < Divisor.
- All arithmetic is unsigned; no overflow is possible, since Quotient ≤ Dividend.

Test Plan:
- dp_width=5, reset pulse, then Start with Dividend=5'b10111 (23), Divisor=5'b00101 (5):
  - Ready low for exactly 5 cycles.
  - Then Quotient=00100 (4), Remainder=00011 (3), Div_by_zero=0.
- Boundary operands:
  - 31/1 → Q=31, R=0.
  - 31/31 → Q=1, R=0.
  - 7/9 → Q=0, R=7.
  - 0/3 → Q=0, R=0.
  - Exhaustive sweep of all 32×31 nonzero-divisor pairs checked against the invariant.
- Divide by zero, 19/0:
  - Ready never drops.
  - Next cycle Quotient=11111, Remainder=10011, Div_by_zero=1.
  - A following 23/5 clears Div_by_zero and yields 4 r 3.
- Start pulsed again with 30/7 two cycles into a 23/5 operation:
  - Second request ignored; result is 4 r 3; Ready timing unchanged.
- reset=1 on the third cycle of an operation:
  - Next edge gives Ready=1, Quotient=0, Remainder=0, P=0.
  - A fresh 27/4 then yields 6 r 3.
- Start held high with constant 20/6:
  - Ready pattern repeats as 5 low, 1 high.
  - Each result is 3 r 2.
